wb_arbiter: RTL and testbench

//  Collects results from NUM_EU execution units and merges them onto the ROB's
//  4-wide writeback port (wb_valid/wb_tag/wb_data).
//  - One FIFO per unit absorbs bursts.
//  - Round-robin selection picks up to WB_PORTS results per cycle.
//  - Outputs are registered.
//  - Buffered results younger than a mispredicted branch are squashed.

---
 rtl/wb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-unit result FIFOs merged round-robin onto a WB_PORTS-wide registered ROB writeback port.
// Optional macro WB_BYPASS_EN lets an empty FIFO offer its incoming result straight to arbitration.
module wb_arbiter #(
  parameter int NUM_EU     = 6,
  parameter int WB_PORTS   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8,
  parameter int ROB_IDX_W  = 6,
  parameter int DATA_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stop,
  input  logic [NUM_EU-1:0]          eu_valid,
  output logic [NUM_EU-1:0]          eu_ready,
  input  logic [NUM_EU*TAG_W-1:0]    eu_tag,
  input  logic [NUM_EU*DATA_W-1:0]   eu_data,
  input  logic                       flush_valid,
  input  logic [TAG_W-1:0]           flush_tag,
  input  logic [ROB_IDX_W-1:0]       rob_head,
  output logic [WB_PORTS-1:0]        wb_valid,
  output logic [WB_PORTS*TAG_W-1:0]  wb_tag,
  output logic [WB_PORTS*DATA_W-1:0] wb_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

  logic                      fifo_live [NUM_EU][FIFO_DEPTH];
  logic [TAG_W-1:0]          fifo_tag  [NUM_EU][FIFO_DEPTH];
  logic [DATA_W-1:0]         fifo_data [NUM_EU][FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr    [NUM_EU];
  logic [PTR_W-1:0]          wr_ptr    [NUM_EU];
  logic [CNT_W-1:0]          count     [NUM_EU];
  logic [RR_W-1:0]           rr_ptr;

  logic [NUM_EU-1:0]         head_valid;
  logic [NUM_EU-1:0]         head_live;
  logic [NUM_EU-1:0]         head_bypass;
  logic [TAG_W-1:0]          head_tag  [NUM_EU];
  logic [DATA_W-1:0]         head_data [NUM_EU];
  int                        scan_pos  [NUM_EU];

  logic [NUM_EU-1:0]         grant;
  logic [NUM_EU-1:0]         pop;
  logic [NUM_EU-1:0]         fifo_pop;
  logic [NUM_EU-1:0]         push_en;
  logic [RR_W-1:0]           last_unit;
  logic [WB_PORTS-1:0]       nxt_valid;
  logic [WB_PORTS*TAG_W-1:0] nxt_tag;
  logic [WB_PORTS*DATA_W-1:0] nxt_data;

  logic [ROB_IDX_W-1:0]      flush_age;
  logic                      unused_flush_tag;

  // Ages are distances from the ROB head; only the low index bits of a tag take part.
  assign flush_age        = flush_tag[ROB_IDX_W-1:0] - rob_head;
  assign unused_flush_tag = ^flush_tag;

  function automatic logic is_younger(input logic [TAG_W-1:0] t);
    logic [ROB_IDX_W-1:0] t_age;
    t_age = t[ROB_IDX_W-1:0] - rob_head;
    return flush_valid && (t_age > flush_age);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_EU; i++) begin
      eu_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_EU; i++) begin
      head_valid[i]  = (count[i] != '0);
      head_live[i]   = fifo_live[i][rd_ptr[i]];
      head_tag[i]    = fifo_tag[i][rd_ptr[i]];
      head_data[i]   = fifo_data[i][rd_ptr[i]];
      head_bypass[i] = 1'b0;
`ifdef WB_BYPASS_EN
      if ((count[i] == '0) && eu_valid[i]) begin
        head_valid[i]  = 1'b1;
        head_live[i]   = 1'b1;
        head_tag[i]    = eu_tag[i*TAG_W +: TAG_W];
        head_data[i]   = eu_data[i*DATA_W +: DATA_W];
        head_bypass[i] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    for (int u = 0; u < NUM_EU; u++) begin
      scan_pos[u] = (u >= int'(rr_ptr)) ? (u - int'(rr_ptr)) : (u - int'(rr_ptr) + NUM_EU);
    end
  end

  // Dead heads are discarded even once every slot is taken, since they need no slot.
  always_comb begin
    int n;
    n         = 0;
    grant     = '0;
    pop       = '0;
    last_unit = '0;
    nxt_valid = '0;
    nxt_tag   = '0;
    nxt_data  = '0;
    for (int k = 0; k < NUM_EU; k++) begin
      for (int u = 0; u < NUM_EU; u++) begin
        if (!stop && (scan_pos[u] == k) && head_valid[u]) begin
          if (!head_live[u]) begin
            pop[u] = 1'b1;
          end else if (n < WB_PORTS) begin
            grant[u]  = 1'b1;
            pop[u]    = 1'b1;
            last_unit = RR_W'(u);
            for (int s = 0; s < WB_PORTS; s++) begin
              if (s == n) begin
                nxt_valid[s]                 = ~is_younger(head_tag[u]);
                nxt_tag[s*TAG_W +: TAG_W]    = head_tag[u];
                nxt_data[s*DATA_W +: DATA_W] = head_data[u];
              end
            end
            n = n + 1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_EU; i++) begin
      fifo_pop[i] = pop[i] & ~head_bypass[i];
      push_en[i]  = eu_valid[i] & eu_ready[i] & ~(head_bypass[i] & grant[i])
                    & ~is_younger(eu_tag[i*TAG_W +: TAG_W]);
    end
  end

  // A younger push is accepted by the handshake but never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_EU; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        for (int d = 0; d < FIFO_DEPTH; d++) begin
          fifo_live[i][d] <= 1'b0;
        end
      end
      rr_ptr   <= '0;
      wb_valid <= '0;
      wb_tag   <= '0;
      wb_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_EU; i++) begin
        for (int d = 0; d < FIFO_DEPTH; d++) begin
          if (is_younger(fifo_tag[i][d])) begin
            fifo_live[i][d] <= 1'b0;
          end
        end
        if (push_en[i]) begin
          fifo_live[i][wr_ptr[i]] <= 1'b1;
          wr_ptr[i]               <= wr_ptr[i] + 1'b1;
        end
        if (fifo_pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        count[i] <= count[i] + CNT_W'(push_en[i]) - CNT_W'(fifo_pop[i]);
      end
      if (!stop) begin
        wb_valid <= nxt_valid;
        wb_tag   <= nxt_tag;
        wb_data  <= nxt_data;
        if (|grant) begin
          rr_ptr <= (last_unit == RR_W'(NUM_EU - 1)) ? '0 : last_unit + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EU; i++) begin
      if (push_en[i]) begin
        fifo_tag[i][wr_ptr[i]]  <= eu_tag[i*TAG_W +: TAG_W];
        fifo_data[i][wr_ptr[i]] <= eu_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: queue-based reference model of wb_arbiter, directed scenarios plus random traffic.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         stop;
  logic [5:0]   eu_valid;
  logic [5:0]   eu_ready;
  logic [47:0]  eu_tag;
  logic [191:0] eu_data;
  logic         flush_valid;
  logic [7:0]   flush_tag;
  logic [5:0]   rob_head;
  logic [3:0]   wb_valid;
  logic [31:0]  wb_tag;
  logic [127:0] wb_data;

  int errors = 0;
  int checks = 0;

`ifdef WB_BYPASS_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 1;
`endif

  wb_arbiter dut (
    .clk(clk), .reset(reset), .stop(stop),
    .eu_valid(eu_valid), .eu_ready(eu_ready), .eu_tag(eu_tag), .eu_data(eu_data),
    .flush_valid(flush_valid), .flush_tag(flush_tag), .rob_head(rob_head),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        live;
    logic [7:0]  tag;
    logic [31:0] data;
  } ent_t;

  ent_t         mq [6][$];
  int           m_rr = 0;
  bit           model_on = 1'b0;
  logic [3:0]   exp_valid;
  logic [31:0]  exp_tag;
  logic [127:0] exp_data;
  logic [5:0]   exp_ready;

  function automatic int age(input logic [7:0] t, input logic [5:0] h);
    return (int'(t[5:0]) - int'(h) + 64) % 64;
  endfunction

  // Reference model: each unit is a queue; one arbitration pass per clock edge.
  always @(posedge clk) begin : model
    int   n, last, u, fa;
    bit   have, fromq;
    ent_t e;
    logic [5:0]   rdy, byp;
    logic [3:0]   nv;
    logic [31:0]  nt;
    logic [127:0] nd;
    if (reset) begin
      for (int i = 0; i < 6; i++) mq[i].delete();
      m_rr = 0; exp_valid = '0; exp_tag = '0; exp_data = '0;
      model_on = 1'b1;
    end else begin
      fa = age(flush_tag, rob_head);
      byp = '0;
      for (int i = 0; i < 6; i++) rdy[i] = (mq[i].size() < 4);
      if (!stop) begin
        n = 0; last = 0; nv = '0; nt = '0; nd = '0;
        for (int k = 0; k < 6; k++) begin
          u = (m_rr + k) % 6;
          have = 1'b0; fromq = 1'b0; e = '0;
          if (mq[u].size() > 0) begin
            e = mq[u][0]; have = 1'b1; fromq = 1'b1;
          end
`ifdef WB_BYPASS_EN
          else if (eu_valid[u]) begin
            e = {1'b1, eu_tag[u*8 +: 8], eu_data[u*32 +: 32]}; have = 1'b1;
          end
`endif
          if (have) begin
            if (!e.live) begin
              void'(mq[u].pop_front());
            end else if (n < 4) begin
              nv[n] = !(flush_valid && (age(e.tag, rob_head) > fa));
              nt[n*8 +: 8] = e.tag;
              nd[n*32 +: 32] = e.data;
              if (fromq) void'(mq[u].pop_front());
              else byp[u] = 1'b1;
              last = u;
              n = n + 1;
            end
          end
        end
        if (n > 0) m_rr = (last + 1) % 6;
        exp_valid = nv; exp_tag = nt; exp_data = nd;
      end
      for (int i = 0; i < 6; i++) begin
        if (eu_valid[i] && !rdy[i])
          $display("[TB] note: push to full unit %0d ignored, result lost", i);
        if (eu_valid[i] && rdy[i] && !byp[i] &&
            !(flush_valid && (age(eu_tag[i*8 +: 8], rob_head) > fa)))
          mq[i].push_back({1'b1, eu_tag[i*8 +: 8], eu_data[i*32 +: 32]});
      end
      if (flush_valid) begin
        for (int i = 0; i < 6; i++) begin
          for (int j = 0; j < mq[i].size(); j++) begin
            e = mq[i][j];
            if (age(e.tag, rob_head) > fa) begin
              e.live = 1'b0;
              mq[i][j] = e;
            end
          end
        end
      end
    end
    for (int i = 0; i < 6; i++) exp_ready[i] = (mq[i].size() < 4);
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("wb_valid", {124'd0, wb_valid}, {124'd0, exp_valid});
      checkOutput("wb_tag",   {96'd0, wb_tag},    {96'd0, exp_tag});
      checkOutput("wb_data",  wb_data,            exp_data);
      checkOutput("eu_ready", {122'd0, eu_ready}, {122'd0, exp_ready});
    end
  end

  task automatic setPush(input int u, input logic [7:0] t, input logic [31:0] d);
    eu_valid[u]       = 1'b1;
    eu_tag[u*8 +: 8]  = t;
    eu_data[u*32 +: 32] = d;
  endtask

  // Holds the current inputs for one edge, then drops the one-shot push/flush strobes.
  task automatic applyStimulus(input int cycles);
    if (cycles > 0) begin
      @(negedge clk);
      eu_valid = '0;
      flush_valid = 1'b0;
      repeat (cycles - 1) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; eu_valid = '0; eu_tag = '0; eu_data = '0;
    flush_valid = 1'b0; flush_tag = '0; rob_head = '0;
    applyStimulus(2);
    checkOutput("reset_valid", {124'd0, wb_valid}, 128'd0);
    checkOutput("reset_ready", {122'd0, eu_ready}, 128'h3f);
    reset = 1'b0;

    // Single result through unit 0
    setPush(0, 8'd5, 32'hAA);
    applyStimulus(1);
    applyStimulus(EXTRA);
    checkOutput("t1_valid", {124'd0, wb_valid}, 128'h1);
    checkOutput("t1_tag",   {120'd0, wb_tag[7:0]}, 128'd5);
    checkOutput("t1_data",  {96'd0, wb_data[31:0]}, 128'hAA);

    // All six units at once from rr_ptr=0
    reset = 1'b1; applyStimulus(1); reset = 1'b0;
    for (int i = 0; i < 6; i++) setPush(i, 8'(10 + i), 32'(100 + i));
    applyStimulus(1);
    applyStimulus(EXTRA);
    checkOutput("t2a_valid", {124'd0, wb_valid}, 128'hF);
    checkOutput("t2a_tag",   {96'd0, wb_tag}, 128'h0D0C0B0A);
    checkOutput("t2a_data0", {96'd0, wb_data[31:0]}, 128'd100);
    applyStimulus(1);
    checkOutput("t2b_valid", {124'd0, wb_valid}, 128'h3);
    checkOutput("t2b_tag",   {96'd0, wb_tag}, 128'h00000F0E);
    setPush(5, 8'd45, 32'h45);
    setPush(0, 8'd40, 32'h40);
    applyStimulus(1);
    applyStimulus(EXTRA);
    checkOutput("t2c_rr_slot0", {120'd0, wb_tag[7:0]}, 128'd40);
    checkOutput("t2c_rr_slot1", {120'd0, wb_tag[15:8]}, 128'd45);

    // Fill unit 2 during a stall, overflow once, then drain in order
    stop = 1'b1;
    for (int j = 0; j < 4; j++) begin
      setPush(2, 8'(20 + j), 32'(200 + j));
      applyStimulus(1);
    end
    checkOutput("t3_ready", {122'd0, eu_ready}, 128'h3B);
    setPush(2, 8'd24, 32'd204);
    applyStimulus(1);
    stop = 1'b0;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1);
      checkOutput("t3_drain_valid", {124'd0, wb_valid}, 128'h1);
      checkOutput("t3_drain_tag", {120'd0, wb_tag[7:0]}, 128'(20 + j));
    end
    applyStimulus(1);
    checkOutput("t3_empty", {124'd0, wb_valid}, 128'd0);

    // Flush with wrapped ages: rob_head=60, tags 62,1,3, branch tag 1
    rob_head = 6'd60;
    stop = 1'b1;
    setPush(0, 8'd62, 32'h62);
    setPush(1, 8'd1, 32'h01);
    setPush(2, 8'd3, 32'h03);
    applyStimulus(1);
    flush_valid = 1'b1; flush_tag = 8'd1;
    applyStimulus(1);
    stop = 1'b0;
    applyStimulus(1);
    checkOutput("t4_valid", {124'd0, wb_valid}, 128'h3);
    checkOutput("t4_tag", {112'd0, wb_tag[15:0]}, 128'h013E);

    // Stall holds the 0011 writeback, then releases
    stop = 1'b1;
    setPush(3, 8'd7, 32'h77);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1);
      checkOutput("t5_hold_valid", {124'd0, wb_valid}, 128'h3);
      checkOutput("t5_hold_tag", {112'd0, wb_tag[15:0]}, 128'h013E);
    end
    stop = 1'b0;
    applyStimulus(1);
    checkOutput("t5_release_valid", {124'd0, wb_valid}, 128'h1);
    checkOutput("t5_release_tag", {120'd0, wb_tag[7:0]}, 128'd7);

    // Reset with three results buffered
    stop = 1'b1;
    setPush(0, 8'd30, 32'h30);
    setPush(1, 8'd31, 32'h31);
    setPush(4, 8'd32, 32'h32);
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("t6_valid", {124'd0, wb_valid}, 128'd0);
    checkOutput("t6_ready", {122'd0, eu_ready}, 128'h3f);
    reset = 1'b0; stop = 1'b0;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1);
      checkOutput("t6_nothing", {124'd0, wb_valid}, 128'd0);
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = (($urandom % 400) == 0);
      stop  = (($urandom % 8) == 0);
      for (int i = 0; i < 6; i++) begin
        eu_valid[i] = (($urandom % 2) == 1) && exp_ready[i];
        eu_tag[i*8 +: 8] = 8'($urandom);
        eu_data[i*32 +: 32] = $urandom;
      end
      if (($urandom % 4) == 0) rob_head = rob_head + 6'd1;
      flush_valid = (($urandom % 10) == 0);
      flush_tag = (($urandom % 3) == 0) ? {2'b00, rob_head - 6'd1} : 8'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; stop = 1'b0; eu_valid = '0; flush_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
